// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised FIFO.
package fifo_pkg;

   localparam int RD_SHOWAHEAD  = 0;
   localparam int RD_REGISTERED = 1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value >= 2) && ((value & (value - 1)) == 0);
   endfunction

   function automatic bit params_legal(input int width, input int depth,
                                       input int af_level, input int ae_level,
                                       input int rd_mode);
      return (width >= 1) && is_pow2(depth)
         && (af_level >= 1) && (af_level <= depth)
         && (ae_level >= 0) && (ae_level <= depth - 1)
         && ((rd_mode == RD_SHOWAHEAD) || (rd_mode == RD_REGISTERED));
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer: increments on enable, loads (flush) with priority, clears on reset.
module fifo_ptr #(
   parameter int PW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc_i,
   input  logic          load_i,
   input  logic [PW-1:0] load_val_i,
   output logic [PW-1:0] ptr_o
);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (load_i) begin
         ptr_d = load_val_i;
      end else if (inc_i) begin
         ptr_d = ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy/threshold flags, flush,
// sticky error flags and selectable show-ahead or registered read data.
module fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1,
   parameter int RD_MODE  = 0,
   localparam int AW      = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] io_din,
   input  logic             io_push,
   input  logic             io_pop,
   input  logic             io_flush,
   input  logic             io_clear_err,
   output logic [WIDTH-1:0] io_dout,
   output logic             io_empty,
   output logic             io_full,
   output logic             io_almost_empty,
   output logic             io_almost_full,
   output logic [AW:0]      io_count,
   output logic             io_overflow,
   output logic             io_underflow
);

   localparam logic [AW:0] AF_CNT = (AW + 1)'(AF_LEVEL);
   localparam logic [AW:0] AE_CNT = (AW + 1)'(AE_LEVEL);

   if (!params_legal(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL, RD_MODE)) begin : g_bad_params
      $error("fifo_param: illegal parameter combination");
   end

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;
   logic             full;
   logic             pop_ok;
   logic             push_ok;
   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok  = io_pop & ~empty;
   assign push_ok = io_push & (~full | pop_ok);
   // Flush overrides both ports: nothing is written and the read pointer jumps to the write pointer.
   assign wr_en   = push_ok & ~io_flush;
   assign rd_en   = pop_ok & ~io_flush;

   fifo_ptr #(.PW(AW + 1)) u_wr_ptr (
      .clk        (clk),
      .reset      (reset),
      .inc_i      (wr_en),
      .load_i     (1'b0),
      .load_val_i ('0),
      .ptr_o      (wr_ptr)
   );

   fifo_ptr #(.PW(AW + 1)) u_rd_ptr (
      .clk        (clk),
      .reset      (reset),
      .inc_i      (rd_en),
      .load_i     (io_flush),
      .load_val_i (wr_ptr),
      .ptr_o      (rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (!reset && wr_en) begin
         mem_q[wr_ptr[AW-1:0]] <= io_din;
      end
   end

   // A new error wins over a clear in the same cycle; flush leaves the flags alone.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (!io_flush) begin
         if (io_push && !push_ok) ovf_d = 1'b1;
         else if (io_clear_err)   ovf_d = 1'b0;
         if (io_pop && empty)     unf_d = 1'b1;
         else if (io_clear_err)   unf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   if (RD_MODE == RD_REGISTERED) begin : g_rd_reg
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk) begin
         if (reset) begin
            dout_q <= '0;
         end else if (rd_en) begin
            dout_q <= mem_q[rd_ptr[AW-1:0]];
         end
      end
      assign io_dout = dout_q;
   end else begin : g_rd_showahead
      assign io_dout = mem_q[rd_ptr[AW-1:0]];
   end

   assign io_count        = wr_ptr - rd_ptr;
   assign io_empty        = empty;
   assign io_full         = full;
   assign io_almost_empty = (io_count <= AE_CNT);
   assign io_almost_full  = (io_count >= AF_CNT);
   assign io_overflow     = ovf_q;
   assign io_underflow    = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed plus random bench for fifo_param: a show-ahead and a registered
// instance share stimulus and are compared against a queue-based model.
module tb_fifo_param;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AF    = 3;
   localparam int AE    = 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] din;
   logic             push, pop, flush, clr;

   logic [WIDTH-1:0] dout_a, dout_b;
   logic             empty_a, full_a, ae_a, af_a, ovf_a, unf_a;
   logic             empty_b, full_b, ae_b, af_b, ovf_b, unf_b;
   logic [2:0]       count_a, count_b;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] mq[$];
   logic             m_ovf, m_unf;
   logic [WIDTH-1:0] m_dreg;

   always #5 clk = ~clk;

   fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .RD_MODE(0)) u_sa (
      .clk(clk), .reset(reset), .io_din(din), .io_push(push), .io_pop(pop),
      .io_flush(flush), .io_clear_err(clr), .io_dout(dout_a), .io_empty(empty_a),
      .io_full(full_a), .io_almost_empty(ae_a), .io_almost_full(af_a),
      .io_count(count_a), .io_overflow(ovf_a), .io_underflow(unf_a));

   fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .RD_MODE(1)) u_rg (
      .clk(clk), .reset(reset), .io_din(din), .io_push(push), .io_pop(pop),
      .io_flush(flush), .io_clear_err(clr), .io_dout(dout_b), .io_empty(empty_b),
      .io_full(full_b), .io_almost_empty(ae_b), .io_almost_full(af_b),
      .io_count(count_b), .io_overflow(ovf_b), .io_underflow(unf_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_status();
      int n;
      n = mq.size();
      chk("count_sa", 32'(count_a), 32'(n));
      chk("count_rg", 32'(count_b), 32'(n));
      chk("empty_sa", 32'(empty_a), 32'(n == 0));
      chk("empty_rg", 32'(empty_b), 32'(n == 0));
      chk("full_sa",  32'(full_a),  32'(n == DEPTH));
      chk("full_rg",  32'(full_b),  32'(n == DEPTH));
      chk("aempty",   32'(ae_a),    32'(n <= AE));
      chk("afull",    32'(af_a),    32'(n >= AF));
      chk("aempty_rg",32'(ae_b),    32'(n <= AE));
      chk("afull_rg", 32'(af_b),    32'(n >= AF));
      chk("ovf_sa",   32'(ovf_a),   32'(m_ovf));
      chk("unf_sa",   32'(unf_a),   32'(m_unf));
      chk("ovf_rg",   32'(ovf_b),   32'(m_ovf));
      chk("unf_rg",   32'(unf_b),   32'(m_unf));
      chk("dout_rg",  32'(dout_b),  32'(m_dreg));
      if (n != 0) chk("dout_sa", 32'(dout_a), 32'(mq[0]));
   endtask

   // One clock: drive inputs, step the model at the edge, check just after it.
   task automatic cycle(input logic r, input logic [WIDTH-1:0] d, input logic pu,
                        input logic po, input logic fl, input logic ce);
      bit emp, pop_ok, push_ok;
      reset = r; din = d; push = pu; pop = po; flush = fl; clr = ce;
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
         m_dreg = '0;
      end else if (fl) begin
         mq.delete();
      end else begin
         emp     = (mq.size() == 0);
         pop_ok  = po && !emp;
         push_ok = pu && ((mq.size() < DEPTH) || pop_ok);
         if (pop_ok)  m_dreg = mq.pop_front();
         if (push_ok) mq.push_back(d);
         if (pu && !push_ok) m_ovf = 1'b1;
         else if (ce)        m_ovf = 1'b0;
         if (po && emp)      m_unf = 1'b1;
         else if (ce)        m_unf = 1'b0;
      end
      #1;
      check_status();
   endtask

   initial begin
      logic [WIDTH-1:0] exp_list [4];
      reset = 1'b1; din = '0; push = 0; pop = 0; flush = 0; clr = 0;
      m_ovf = 0; m_unf = 0; m_dreg = '0;

      cycle(1, 8'h00, 0, 0, 0, 0);
      cycle(1, 8'h00, 0, 0, 0, 0);
      chk("rst_empty", 32'(empty_a), 32'd1);
      chk("rst_dout_rg", 32'(dout_b), 32'd0);

      // Fill
      for (int i = 0; i < 4; i++) begin
         cycle(0, 8'(8'h11 * (i + 1)), 1, 0, 0, 0);
         chk("fill_count", 32'(count_a), 32'(i + 1));
         chk("fill_afull", 32'(af_a), 32'(i + 1 >= 3));
      end
      chk("fill_full", 32'(full_a), 32'd1);

      // Overflow while full, then clear
      cycle(0, 8'h55, 1, 0, 0, 0);
      chk("ovf_set", 32'(ovf_a), 32'd1);
      cycle(0, 8'h00, 0, 0, 0, 1);
      chk("ovf_clr", 32'(ovf_a), 32'd0);

      // Push and pop together while full
      chk("full_head", 32'(dout_a), 32'h11);
      cycle(0, 8'h66, 1, 1, 0, 0);
      chk("pp_count", 32'(count_a), 32'd4);
      chk("pp_dout_rg", 32'(dout_b), 32'h11);

      exp_list = '{8'h22, 8'h33, 8'h44, 8'h66};
      for (int i = 0; i < 4; i++) begin
         chk("drain_sa", 32'(dout_a), 32'(exp_list[i]));
         cycle(0, 8'h00, 0, 1, 0, 0);
         chk("drain_rg", 32'(dout_b), 32'(exp_list[i]));
      end
      chk("drain_empty", 32'(empty_a), 32'd1);
      chk("drain_noerr", 32'({ovf_a, unf_a}), 32'd0);

      // Underflow, then push+pop on empty
      cycle(0, 8'h00, 0, 1, 0, 0);
      chk("unf_set", 32'(unf_a), 32'd1);
      cycle(0, 8'hA5, 1, 1, 0, 0);
      chk("ep_count", 32'(count_a), 32'd1);
      chk("ep_dout", 32'(dout_a), 32'hA5);
      cycle(0, 8'h00, 0, 0, 0, 1);

      // Pointer wrap with paired traffic
      for (int i = 0; i < 10; i++) cycle(0, 8'($urandom), 1, 1, 0, 0);
      cycle(0, 8'h00, 0, 1, 0, 0);

      // Flush at count 3 with a push in the same cycle
      for (int i = 0; i < 3; i++) cycle(0, 8'(8'h70 + i), 1, 0, 0, 0);
      chk("pre_flush", 32'(count_a), 32'd3);
      cycle(0, 8'h77, 1, 0, 1, 0);
      chk("flush_empty", 32'(empty_a), 32'd1);

      // Registered read mode
      cycle(0, 8'h01, 1, 0, 0, 0);
      cycle(0, 8'h02, 1, 0, 0, 0);
      cycle(0, 8'h00, 0, 1, 0, 0);
      chk("rg_first", 32'(dout_b), 32'h01);
      cycle(0, 8'h00, 0, 0, 0, 0);
      chk("rg_hold", 32'(dout_b), 32'h01);
      cycle(0, 8'h00, 0, 0, 1, 0);
      chk("rg_flush_hold", 32'(dout_b), 32'h01);
      cycle(0, 8'h00, 0, 1, 0, 0);
      cycle(0, 8'h09, 1, 0, 0, 0);
      cycle(1, 8'h00, 0, 0, 0, 0);
      chk("mid_rst_count", 32'(count_b), 32'd0);
      chk("mid_rst_dout", 32'(dout_b), 32'd0);
      chk("mid_rst_unf", 32'(unf_b), 32'd0);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         cycle($urandom_range(0, 199) == 0, 8'($urandom),
               $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
               $urandom_range(0, 99) < 3,  $urandom_range(0, 99) < 5);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
